// File: rtl/lbl_pkg.sv
// Label constants shared by every labelled stage.
// Domain mapping: a label of 0 is the L domain and a label of 1 is the H domain.
package lbl_pkg;
   localparam int unsigned LBL_W = 1;

   typedef logic [LBL_W-1:0] lbl_t;

   localparam lbl_t LBL_L = 1'b0;
   localparam lbl_t LBL_H = 1'b1;

   function automatic logic lbl_is_high(input lbl_t l);
      return l == LBL_H;
   endfunction
endpackage

// File: rtl/lbl_fifo_slot.sv
// One buffer slot: a label/data register pair.
// A write stores both fields together. A scrub clears both fields together.
module lbl_slot
   import lbl_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic             scrub,
   input  lbl_t             wr_lbl,
   input  logic [WIDTH-1:0] wr_data,
   output lbl_t             lbl,
   output logic [WIDTH-1:0] data
);
   lbl_t             r_lbl;
   logic [WIDTH-1:0] r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lbl  <= LBL_L;
         r_data <= '0;
      end else if (wr_en) begin
         r_lbl  <= wr_lbl;
         r_data <= wr_data;
      end else if (scrub) begin
         r_lbl  <= LBL_L;
         r_data <= '0;
      end
   end

   assign lbl  = r_lbl;
   assign data = r_data;
endmodule

// File: rtl/lbl_fifo.sv
// In-order buffer for (label, data) pairs with a valid/ready handshake on both sides.
// Each freed slot is scrubbed to 0/0. Control logic never looks at labels or data.
module lbl_fifo
   import lbl_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_valid,
   output logic                       push_ready,
   input  logic                       push_lbl,
   input  logic [WIDTH-1:0]           push_data,
   output logic                       pop_valid,
   input  logic                       pop_ready,
   output logic                       pop_lbl,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;
   lbl_t             w_slot_lbl  [DEPTH];
   logic [WIDTH-1:0] w_slot_data [DEPTH];

   assign push_ready = (r_count != CW'(DEPTH));
   assign pop_valid  = (r_count != '0);
   assign w_push     = push_valid && push_ready;
   assign w_pop      = pop_valid && pop_ready;

   // A write and a scrub never hit the same slot on one edge.
   // That could only happen when empty (no pop) or when full (no push).
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      lbl_slot #(.WIDTH(WIDTH)) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_en   (w_push && (r_wr_ptr == PW'(gi))),
         .scrub   (w_pop && (r_rd_ptr == PW'(gi))),
         .wr_lbl  (push_lbl),
         .wr_data (push_data),
         .lbl     (w_slot_lbl[gi]),
         .data    (w_slot_data[gi])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign pop_lbl  = w_slot_lbl[r_rd_ptr];
   assign pop_data = w_slot_data[r_rd_ptr];
   assign count    = r_count;
endmodule
